cn_ff_driver: RTL and testbench

Transmit-side driver for a CN (change/no-change) flip-flop: accepts parallel words over a valid/ready handshake, serializes them LSB-first onto the flip-flop's `c`/`n` inputs, and checks the flip-flop's `q` feedback against the intended bit stream. It sits in front of a `cn_ff` instance and owns all writes to it. It asserts `c` only when the stored bit must change, so the flip-flop holds on every repeated bit.

---
 rtl/cn_ff_driver_if.sv | 25 ++
 rtl/cn_ff_driver.sv | 150 +++++++++++++++
 tb/tb_cn_ff_driver.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cn_ff_driver_if.sv
// Handshake and flip-flop side signals of the CN flip-flop driver.
// The master modport is the upstream/flip-flop side; the slave modport is the driver.
interface cn_ff_driver_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             c;
  logic             n;
  logic             q_fb;
  logic             done;
  logic             word_err;
  logic [7:0]       err_count;

  modport master (
    output in_valid, in_data, q_fb,
    input  in_ready, c, n, done, word_err, err_count
  );

  modport slave (
    input  in_valid, in_data, q_fb,
    output in_ready, c, n, done, word_err, err_count
  );
endinterface

// File: rtl/cn_ff_driver.sv
// Serializes words LSB-first onto a CN flip-flop, pulsing c only when the stored bit must change,
// and checks q feedback two edges behind the drive.
module cn_ff_driver #(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  cn_ff_driver_if.slave  bus
);

  localparam int unsigned CNT_W   = $clog2(WIDTH + 1);
  localparam int unsigned ERR_W   = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               track_q, track_d;
  logic               track_valid_q, track_valid_d;
  logic               c_q, c_d;
  logic               n_q, n_d;
  logic               exp1_q, exp1_d;
  logic               v1_q, v1_d;
  logic               exp2_q, exp2_d;
  logic               v2_q, v2_d;
  logic               done_q, done_d;
  logic               word_err_q, word_err_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  logic               drive;
  logic               bit_v;
  logic               mismatch;

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sh_q          <= '0;
      cnt_q         <= '0;
      track_q       <= 1'b0;
      track_valid_q <= 1'b0;
      c_q           <= 1'b0;
      n_q           <= 1'b0;
      exp1_q        <= 1'b0;
      v1_q          <= 1'b0;
      exp2_q        <= 1'b0;
      v2_q          <= 1'b0;
      done_q        <= 1'b0;
      word_err_q    <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      sh_q          <= sh_d;
      cnt_q         <= cnt_d;
      track_q       <= track_d;
      track_valid_q <= track_valid_d;
      c_q           <= c_d;
      n_q           <= n_d;
      exp1_q        <= exp1_d;
      v1_q          <= v1_d;
      exp2_q        <= exp2_d;
      v2_q          <= v2_d;
      done_q        <= done_d;
      word_err_q    <= word_err_d;
      err_count_q   <= err_count_d;
    end
  end

  // Next-state, encoding and check pipeline
  always_comb begin
    state_d       = state_q;
    sh_d          = sh_q;
    cnt_d         = cnt_q;
    track_d       = track_q;
    track_valid_d = track_valid_q;
    c_d           = 1'b0;
    n_d           = 1'b0;
    exp1_d        = exp1_q;
    v1_d          = 1'b0;
    exp2_d        = exp1_q;
    v2_d          = v1_q;
    done_d        = 1'b0;
    word_err_d    = word_err_q;
    err_count_d   = err_count_q;
    drive         = 1'b0;
    bit_v         = 1'b0;
    mismatch      = v2_q && (bus.q_fb != exp2_q);

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d    = DRIVE;
          sh_d       = bus.in_data >> 1;
          cnt_d      = CNT_W'(1);
          drive      = 1'b1;
          bit_v      = bus.in_data[0];
          word_err_d = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_W'(WIDTH)) begin
          state_d = DRAIN;
        end else begin
          drive = 1'b1;
          bit_v = sh_q[0];
          sh_d  = sh_q >> 1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Change only when the flip-flop content is unknown or differs from the new bit
    if (drive) begin
      c_d           = !track_valid_q || (bit_v != track_q);
      n_d           = c_d & bit_v;
      track_d       = bit_v;
      track_valid_d = 1'b1;
      exp1_d        = bit_v;
      v1_d          = 1'b1;
    end

    if (mismatch) begin
      word_err_d = 1'b1;
      if (err_count_q != ERR_MAX) begin
        err_count_d = err_count_q + ERR_W'(1);
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.c         = c_q;
  assign bus.n         = n_q;
  assign bus.done      = done_q;
  assign bus.word_err  = word_err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_cn_ff_driver.sv
// Directed bench for cn_ff_driver with a behavioural CN flip-flop and a scoreboard of
// expected per-bit c/n values and per-word results.
module tb_cn_ff_driver;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic force0 = 1'b0;
  logic ff_q = 1'b0;

  always #5 clk = ~clk;

  cn_ff_driver_if #(.WIDTH(WIDTH)) bus ();

  cn_ff_driver #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural cn_ff: next q = c ? n : q
  always @(posedge clk) if (bus.c) ff_q <= bus.n;
  assign bus.q_fb = force0 ? 1'b0 : ff_q;

  typedef struct { logic c; logic n; } bit_exp_t;
  typedef struct { logic werr; logic [7:0] cnt; } word_exp_t;

  bit_exp_t  bit_q[$];
  word_exp_t word_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_pulses = 0;
  int accepts[$];

  logic m_track = 1'b0;
  logic m_tv = 1'b0;
  int   m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.done) done_pulses <= done_pulses + 1;
  always @(posedge clk) if (!rst && bus.in_valid && bus.in_ready) accepts.push_back(cyc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoding of one word plus its expected error outcome
  task automatic model_push(input logic [7:0] d);
    int mism;
    logic b, cc;
    mism = 0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      b  = d[i];
      cc = !m_tv || (b != m_track);
      bit_q.push_back('{c: cc, n: cc & b});
      m_track = b;
      m_tv    = 1'b1;
      if (force0 && b) mism++;
    end
    m_cnt = (m_cnt + mism > 255) ? 255 : m_cnt + mism;
    word_q.push_back('{werr: (mism != 0), cnt: 8'(m_cnt)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_tv = 1'b0;
    m_cnt = 0;
    bit_q.delete();
    word_q.delete();
  endtask

  task automatic send_word(input logic [7:0] d, input bit keep_valid, input int abort_bit);
    int waited;
    bit_exp_t  be;
    word_exp_t we;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("ready_before_accept", 32'(bus.in_ready), 32'(1));
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    model_push(d);
    @(posedge clk); #1;
    if (!keep_valid) bus.in_valid = 1'b0;
    bus.in_data = ~d;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      be = bit_q.pop_front();
      chk($sformatf("c_bit%0d_%02h", i, d), 32'(bus.c), 32'(be.c));
      chk($sformatf("n_bit%0d_%02h", i, d), 32'(bus.n), 32'(be.n));
      chk("ready_low_in_word", 32'(bus.in_ready), 32'(0));
      if (i == abort_bit) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_c", 32'(bus.c), 32'(0));
        chk("abort_n", 32'(bus.n), 32'(0));
        chk("abort_ready", 32'(bus.in_ready), 32'(1));
        chk("abort_done", 32'(bus.done), 32'(0));
        m_tv = 1'b0;
        m_cnt = 0;
        bit_q.delete();
        word_q.delete();
        return;
      end
    end
    @(posedge clk); #1;
    chk("drain_c", 32'(bus.c), 32'(0));
    chk("drain_n", 32'(bus.n), 32'(0));
    chk("drain_done", 32'(bus.done), 32'(0));
    @(posedge clk); #1;
    we = word_q.pop_front();
    chk($sformatf("done_%02h", d), 32'(bus.done), 32'(1));
    chk($sformatf("word_err_%02h", d), 32'(bus.word_err), 32'(we.werr));
    chk($sformatf("err_count_%02h", d), 32'(bus.err_count), 32'(we.cnt));
    chk("ready_with_done", 32'(bus.in_ready), 32'(1));
    if (!keep_valid) begin
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(bus.done), 32'(0));
      chk("word_err_hold", 32'(bus.word_err), 32'(we.werr));
    end
  endtask

  initial begin
    int dp;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    do_reset();
    chk("rst_c", 32'(bus.c), 32'(0));
    chk("rst_n", 32'(bus.n), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_word_err", 32'(bus.word_err), 32'(0));
    chk("rst_err_count", 32'(bus.err_count), 32'(0));
    chk("rst_ready", 32'(bus.in_ready), 32'(1));

    send_word(8'hA5, 1'b0, -1);

    do_reset();
    send_word(8'h00, 1'b0, -1);
    send_word(8'h00, 1'b0, -1);
    send_word(8'hFF, 1'b0, -1);

    do_reset();
    force0 = 1'b1;
    send_word(8'hFF, 1'b0, -1);
    for (int k = 0; k < 33; k++) send_word(8'hFF, 1'b0, -1);
    chk("err_count_saturated", 32'(bus.err_count), 32'(255));
    force0 = 1'b0;
    send_word(8'h00, 1'b0, -1);
    chk("err_count_stays", 32'(bus.err_count), 32'(255));

    do_reset();
    dp = done_pulses;
    send_word(8'h3C, 1'b0, 3);
    repeat (12) @(posedge clk);
    #1;
    chk("no_done_after_abort", 32'(done_pulses), 32'(dp));
    send_word(8'h00, 1'b0, -1);

    accepts.delete();
    dp = done_pulses;
    for (int k = 0; k < 4; k++) send_word((k % 2 == 0) ? 8'h55 : 8'hAA, k < 3, -1);
    chk("b2b_accepts", 32'(accepts.size()), 32'(4));
    for (int i = 1; i < accepts.size(); i++)
      chk($sformatf("accept_spacing_%0d", i), 32'(accepts[i] - accepts[i-1]), 32'(10));
    chk("b2b_done_pulses", 32'(done_pulses - dp), 32'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
